pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5, mult/multu busy length in cycles (2..15).
REQ-002 Parameter DIV_CYC, default 10, div/divu busy length in cycles (2..15).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 ID_rs, ID_rt  input  5 each  ID-stage source register numbers.
REQ-006 ID_Tuse_rs, ID_Tuse_rt  input  2 each  cycles until ID operand is needed (3 = unused).
REQ-007 EX_dst, MEM_dst  input  5 each  destination register of EX/MEM instruction (0 = none).
REQ-008 EX_Tnew, MEM_Tnew  input  2 each  cycles until EX/MEM result is available.
REQ-009 ID_is_md  input  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 md_start  input  1  mult/div instruction is in EX this cycle.
REQ-011 md_is_div  input  1  qualifies md_start: 1 = div, 0 = mult.
REQ-012 ID_eret  input  1  eret in ID.
REQ-013 EX_mtc0_epc, MEM_mtc0_epc  input  1 each  mtc0 to EPC in EX/MEM.
REQ-014 exc_req  input  1  interrupt/exception request from CP0.
REQ-015 pc_en  output  1  PC register enable.
REQ-016 if_id_en  output  1  IF/ID enable.
REQ-017 if_id_flush  output  1  IF/ID flush (qualified by if_id_en downstream).
REQ-018 id_ex_flush  output  1  ID/EX bubble insert.
REQ-019 req  output  1  pipeline-wide flush to handler entry 0x4180.
REQ-020 md_busy  output  1  multiply/divide unit busy.
REQ-021 md_done  output  1  one-cycle pulse, last busy cycle.

Function
REQ-022 hz_rs = (ID_rs!=0) & ((ID_rs==EX_dst & ID_Tuse_rs<EX_Tnew) | (ID_rs==MEM_dst & ID_Tuse_rs<MEM_Tnew)); hz_rt identical for rt; unsigned 2-bit compares.
REQ-023 stall_md = ID_is_md & (md_busy | md_start).
REQ-024 stall_eret = ID_eret & (EX_mtc0_epc | MEM_mtc0_epc).
REQ-025 stall = hz_rs | hz_rt | stall_md | stall_eret, all combinational, same cycle.
REQ-026 pc_en = if_id_en = ~stall; id_ex_flush = stall.
REQ-027 if_id_flush = ID_eret & ~stall (kills fetched post-eret instruction).
REQ-028 req = exc_req, combinational; when req=1, pc_en=1, if_id_en=1, id_ex_flush=0, if_id_flush=0 (req overrides stall and eret).
REQ-029 MD state machine states IDLE, BUSY; 4-bit down-counter cnt.
REQ-030 IDLE & md_start & ~req -> BUSY, cnt = md_is_div ? DIV_CYC : MULT_CYC.
REQ-031 IDLE & md_start & req -> stay IDLE (excepted mult/div not started).
REQ-032 BUSY: cnt decrements each cycle; md_done = (cnt==1); cnt==1 -> IDLE next cycle.
REQ-033 md_busy = 1 exactly while state==BUSY (registered); busy lasts exactly N cycles after the md_start cycle.
REQ-034 md_start while BUSY ignored (no restart, cnt unaffected).
REQ-035 req during BUSY does not abort the counter (started operation completes).

Reset
REQ-036 reset=1 asynchronously forces state=IDLE, cnt=0, md_busy=0, md_done=0; combinational outputs follow inputs with md_busy=0.
REQ-037 Reset deasserted mid-BUSY resumes at IDLE; no md_done emitted for the aborted operation.

Verification
REQ-038 EX_dst=5, EX_Tnew=2, ID_rs=5, ID_Tuse_rs=1 -> stall=1: pc_en=0, if_id_en=0, id_ex_flush=1; EX_dst=0 instead -> no stall.
REQ-039 md_start=1, md_is_div=0 at cycle 0 -> md_busy=1 cycles 1..5, md_done=1 cycle 5 only, md_busy=0 cycle 6; div gives 10 cycles; ID_is_md held -> stall cycles 0..5.
REQ-040 md_start=1 and exc_req=1 same cycle -> req=1, md_busy stays 0; exc_req mid-div -> md_done still at cycle 10.
REQ-041 ID_eret=1, MEM_mtc0_epc=1 -> stall=1, if_id_flush=0; next cycle mtc0 gone -> if_id_flush=1, pc_en=1.
REQ-042 exc_req=1 with load-use hazard active -> req=1, pc_en=1, if_id_en=1, id_ex_flush=0.
REQ-043 reset pulsed asynchronously at cnt=3 of a div -> md_busy=0 immediately, no md_done afterward.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller with a multiply/divide busy tracker.
// Detects operand hazards, md/eret stalls and exception flushes for the five-stage pipeline.
module pipe_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic [1:0] ID_Tuse_rs,
    input  logic [1:0] ID_Tuse_rt,
    input  logic [4:0] EX_dst,
    input  logic [4:0] MEM_dst,
    input  logic [1:0] EX_Tnew,
    input  logic [1:0] MEM_Tnew,
    input  logic       ID_is_md,
    input  logic       md_start,
    input  logic       md_is_div,
    input  logic       ID_eret,
    input  logic       EX_mtc0_epc,
    input  logic       MEM_mtc0_epc,
    input  logic       exc_req,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       req,
    output logic       md_busy,
    output logic       md_done
);

    typedef enum logic {
        IDLE,
        BUSY
    } md_state_t;

    md_state_t  state;
    md_state_t  state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;

    logic hz_rs;
    logic hz_rt;
    logic stall_md;
    logic stall_eret;
    logic stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // An md_start coinciding with an exception never launches; one already running always completes.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (md_start && !exc_req) begin
                    state_next = BUSY;
                    cnt_next   = md_is_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
                end
            end
            BUSY: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    assign md_busy = (state == BUSY);
    assign md_done = (state == BUSY) && (cnt == 4'd1);

    always_comb begin
        hz_rs = (ID_rs != 5'd0) &&
                (((ID_rs == EX_dst)  && (ID_Tuse_rs < EX_Tnew)) ||
                 ((ID_rs == MEM_dst) && (ID_Tuse_rs < MEM_Tnew)));
        hz_rt = (ID_rt != 5'd0) &&
                (((ID_rt == EX_dst)  && (ID_Tuse_rt < EX_Tnew)) ||
                 ((ID_rt == MEM_dst) && (ID_Tuse_rt < MEM_Tnew)));
        stall_md   = ID_is_md && (md_busy || md_start);
        stall_eret = ID_eret && (EX_mtc0_epc || MEM_mtc0_epc);
        stall      = hz_rs || hz_rt || stall_md || stall_eret;
    end

    // The exception flush wins over every stall and over the eret fetch kill.
    assign req         = exc_req;
    assign pc_en       = req || !stall;
    assign if_id_en    = req || !stall;
    assign id_ex_flush = !req && stall;
    assign if_id_flush = !req && ID_eret && !stall;

endmodule
